// File: rtl/bound_add_pkg.sv
// Shared types and sizing helpers for the bottom-pad frame controller.
package bound_add_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACTIVE,
        PAD_GAP,
        PAD_LINE,
        FLUSH
    } state_t;

    function automatic int pad_rows(input int ksz);
        return (ksz - 1) / 2;
    endfunction

    function automatic int row_w(input int ih, input int ksz);
        return $clog2(ih + pad_rows(ksz) + 1);
    endfunction

    function automatic int col_w(input int iw);
        return $clog2(iw + 1);
    endfunction

    function automatic int cnt_w(input int hb, input int iw);
        return $clog2(((hb > iw) ? hb : iw) + 1);
    endfunction

    localparam int ROW_W_DEF = row_w(2, 7);
    localparam int COL_W_DEF = col_w(10);

endpackage

// File: rtl/bound_add_ctrl_if.sv
// Sync/index bundle between the frame source and the bound_add_ctrl block.
interface bound_add_ctrl_if
    import bound_add_pkg::*;
#(
    parameter int RW = ROW_W_DEF,
    parameter int CW = COL_W_DEF
);
    logic          din_vsync;
    logic          din_hsync;
    logic          dout_vsync;
    logic          dout_hsync;
    logic          pad_row;
    logic [RW-1:0] row_idx;
    logic [CW-1:0] col_idx;
    logic          frame_done;
    logic          err;

    modport master (
        output din_vsync, din_hsync,
        input  dout_vsync, dout_hsync, pad_row, row_idx, col_idx, frame_done, err
    );

    modport slave (
        input  din_vsync, din_hsync,
        output dout_vsync, dout_hsync, pad_row, row_idx, col_idx, frame_done, err
    );
endinterface

// File: rtl/bound_add_line_gen.sv
// Gap/pad-line timer: one down-counter reloaded with HB-1 or IW-1 on terminal count.
module bound_add_line_gen
    import bound_add_pkg::*;
#(
    parameter int IW = 10,
    parameter int HB = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_gap,
    input  logic run_line,
    output logic gap_done,
    output logic line_done
);
    localparam int CNTW = cnt_w(HB, IW);
    localparam logic [CNTW-1:0] GAP_LOAD  = CNTW'(HB - 1);
    localparam logic [CNTW-1:0] LINE_LOAD = CNTW'(IW - 1);

    logic [CNTW-1:0] cnt_q;
    logic            tc;

    assign tc        = (cnt_q == '0);
    assign gap_done  = run_gap & tc;
    assign line_done = run_line & tc;

    // Idle time keeps the counter preloaded so the first gap is exactly HB cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= GAP_LOAD;
        end else if (run_gap) begin
            cnt_q <= tc ? LINE_LOAD : cnt_q - CNTW'(1);
        end else if (run_line) begin
            cnt_q <= tc ? GAP_LOAD : cnt_q - CNTW'(1);
        end else begin
            cnt_q <= GAP_LOAD;
        end
    end
endmodule

// File: rtl/bound_add_ctrl.sv
// Frame controller that appends PR generated bottom-pad lines to each frame.
// Optional real-line length check: define BOUND_ADD_CTRL_LEN_CHK_EN.
//
// state    | meaning
// IDLE     | waiting for a fresh din_vsync rising edge
// ACTIVE   | forwarding real lines (sync delayed one cycle)
// PAD_GAP  | HB blank cycles ahead of a pad line
// PAD_LINE | IW cycles of generated pad line
// FLUSH    | dout_vsync low, frame_done pulse
module bound_add_ctrl
    import bound_add_pkg::*;
#(
    parameter int KSZ = 7,
    parameter int IW  = 10,
    parameter int IH  = 2,
    parameter int HB  = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    bound_add_ctrl_if.slave bus
);
    localparam int PR = pad_rows(KSZ);
    localparam int RW = row_w(IH, KSZ);
    localparam int CW = col_w(IW);
    localparam logic [RW-1:0] ROW_REAL_LAST = RW'(IH - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IH + PR - 1);
    localparam logic [CW-1:0] COL_LAST      = CW'(IW - 1);
    localparam logic [CW-1:0] COL_SAT       = CW'(IW);

    state_t        state_q, state_d;
    logic          vs_q, hs_q;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q;
    logic          err_q, err_d, len_err;
    logic          gap_done, line_done;
    logic          vs_rise, hs_rise, act_end, last_end, line_end;
    logic          hsync;

    bound_add_line_gen #(.IW(IW), .HB(HB)) u_line_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_gap   (state_q == PAD_GAP),
        .run_line  (state_q == PAD_LINE),
        .gap_done  (gap_done),
        .line_done (line_done)
    );

    assign vs_rise  = bus.din_vsync & ~vs_q;
    assign hs_rise  = bus.din_hsync & ~hs_q;
    assign act_end  = (state_q == ACTIVE) & hs_q & ~bus.din_hsync;
    assign last_end = act_end & (row_q == ROW_REAL_LAST);
    assign line_end = act_end | line_done;

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (vs_rise) state_d = ACTIVE;
            end
            ACTIVE: begin
                // vsync dropping together with the final line end still counts as complete
                if (!bus.din_vsync && !last_end) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (last_end) begin
                    state_d = PAD_GAP;
                end
            end
            PAD_GAP: begin
                err_d = vs_rise | hs_rise;
                if (gap_done) state_d = PAD_LINE;
            end
            PAD_LINE: begin
                err_d = vs_rise | hs_rise;
                if (line_done) state_d = (row_q == ROW_LAST) ? FLUSH : PAD_GAP;
            end
            FLUSH: begin
                err_d   = vs_rise | hs_rise;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        row_d = row_q;
        if (state_d == IDLE) begin
            row_d = '0;
        end else if (line_end && (row_q != ROW_LAST)) begin
            row_d = row_q + RW'(1);
        end
    end

`ifdef BOUND_ADD_CTRL_LEN_CHK_EN
    logic len_bad_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) len_bad_q <= 1'b0;
        else        len_bad_q <= act_end & (col_q != COL_LAST);
    end

    assign len_err = len_bad_q;
`else
    assign len_err = 1'b0;
`endif

    // vs_q resets high so a vsync already high at reset release is not a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vs_q    <= 1'b1;
            hs_q    <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_q    <= bus.din_vsync;
            hs_q    <= bus.din_hsync;
            row_q   <= row_d;
            err_q   <= err_d | len_err;
            if (hsync) col_q <= (col_q == COL_SAT) ? col_q : col_q + CW'(1);
            else       col_q <= '0;
        end
    end

    assign hsync = ((state_q == ACTIVE) & hs_q) | (state_q == PAD_LINE);

    assign bus.dout_vsync = (state_q == ACTIVE) | (state_q == PAD_GAP) | (state_q == PAD_LINE);
    assign bus.dout_hsync = hsync;
    assign bus.pad_row    = (state_q == PAD_LINE);
    assign bus.row_idx    = row_q;
    assign bus.col_idx    = !hsync ? '0 : ((col_q == COL_SAT) ? COL_LAST : col_q);
    assign bus.frame_done = (state_q == FLUSH);
    assign bus.err        = err_q;
endmodule

// File: tb/tb_bound_add_ctrl.sv
// Directed bench for bound_add_ctrl: KSZ=7 main instance plus KSZ=3/5 pad-count instances.
module tb_bound_add_ctrl;
    import bound_add_pkg::*;

    localparam int IW = 10;
    localparam int IH = 2;
    localparam int HB = 10;
`ifdef BOUND_ADD_CTRL_LEN_CHK_EN
    localparam logic [31:0] LEN_EXP = 32'd1;
`else
    localparam logic [31:0] LEN_EXP = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vs = 1'b0;
    logic hs = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bound_add_ctrl_if #(.RW(row_w(IH, 7)), .CW(col_w(IW))) b0 ();
    bound_add_ctrl_if #(.RW(row_w(IH, 3)), .CW(col_w(IW))) b3 ();
    bound_add_ctrl_if #(.RW(row_w(IH, 5)), .CW(col_w(IW))) b5 ();

    assign b0.din_vsync = vs;
    assign b0.din_hsync = hs;
    assign b3.din_vsync = vs;
    assign b3.din_hsync = hs;
    assign b5.din_vsync = vs;
    assign b5.din_hsync = hs;

    bound_add_ctrl #(.KSZ(7), .IW(IW), .IH(IH), .HB(HB)) dut7 (.clk(clk), .rst_n(rst_n), .bus(b0));
    bound_add_ctrl #(.KSZ(3), .IW(IW), .IH(IH), .HB(HB)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    bound_add_ctrl #(.KSZ(5), .IW(IW), .IH(IH), .HB(HB)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

    int   err_cnt0 = 0, fd_cnt0 = 0, pad_cnt0 = 0, pad_cnt3 = 0, pad_cnt5 = 0;
    logic pr0 = 1'b0, pr3 = 1'b0, pr5 = 1'b0;

    always @(negedge clk) begin
        if (b0.err)        err_cnt0 <= err_cnt0 + 1;
        if (b0.frame_done) fd_cnt0  <= fd_cnt0 + 1;
        if (b0.pad_row && !pr0) pad_cnt0 <= pad_cnt0 + 1;
        if (b3.pad_row && !pr3) pad_cnt3 <= pad_cnt3 + 1;
        if (b5.pad_row && !pr5) pad_cnt5 <= pad_cnt5 + 1;
        pr0 <= b0.pad_row;
        pr3 <= b3.pad_row;
        pr5 <= b5.pad_row;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vsync"}, 32'(b0.dout_vsync), 0);
        chk({tag, "_hsync"}, 32'(b0.dout_hsync), 0);
        chk({tag, "_pad"},   32'(b0.pad_row), 0);
        chk({tag, "_row"},   32'(b0.row_idx), 0);
        chk({tag, "_col"},   32'(b0.col_idx), 0);
        chk({tag, "_fd"},    32'(b0.frame_done), 0);
        chk({tag, "_err"},   32'(b0.err), 0);
    endtask

    // mode 0: plain frame, 1: hsync in gap + vsync rise in 2nd pad line, 2: reset in 1st pad line
    task automatic frame_nom(input int mode);
        int e0, f0, p0, p3, p5;
        e0 = err_cnt0; f0 = fd_cnt0; p0 = pad_cnt0; p3 = pad_cnt3; p5 = pad_cnt5;
        vs = 1'b1; tick();                                  // cycle 1
        chk("vs_rise", 32'(b0.dout_vsync), 1);
        chk("row_start", 32'(b0.row_idx), 0);
        chk("hs_before", 32'(b0.dout_hsync), 0);
        hs = 1'b1; repeat (9) tick();                       // cycle 10
        chk("col_mid", 32'(b0.col_idx), 8);
        tick(); hs = 1'b0;                                  // cycle 11
        chk("col_last", 32'(b0.col_idx), 9);
        chk("hs_last", 32'(b0.dout_hsync), 1);
        tick();                                             // cycle 12
        chk("line0_end_hs", 32'(b0.dout_hsync), 0);
        chk("line0_end_row", 32'(b0.row_idx), 1);
        chk("line0_end_col", 32'(b0.col_idx), 0);
        tick(); tick(); hs = 1'b1;                          // cycle 14
        tick();                                             // cycle 15
        chk("line1_first_col", 32'(b0.col_idx), 0);
        chk("line1_first_hs", 32'(b0.dout_hsync), 1);
        repeat (9) tick(); hs = 1'b0;                       // cycle 24
        chk("line1_last_col", 32'(b0.col_idx), 9);
        tick();                                             // cycle 25
        chk("gap_row", 32'(b0.row_idx), 2);
        chk("gap_hs", 32'(b0.dout_hsync), 0);
        chk("gap_vs", 32'(b0.dout_vsync), 1);
        chk("gap_pad", 32'(b0.pad_row), 0);
        tick(); vs = 1'b0;                                  // cycle 26
        if (mode == 1) begin
            repeat (4) tick(); hs = 1'b1;                   // cycle 30
            tick(); hs = 1'b0;                              // cycle 31
            chk("gap_hs_err", 32'(b0.err), 1);
            repeat (4) tick();                              // cycle 35
        end else begin
            repeat (9) tick();                              // cycle 35
        end
        chk("pad0_pad", 32'(b0.pad_row), 1);
        chk("pad0_hs", 32'(b0.dout_hsync), 1);
        chk("pad0_col", 32'(b0.col_idx), 0);
        chk("pad0_row", 32'(b0.row_idx), 2);
        if (mode == 2) begin
            repeat (5) tick();                              // cycle 40
            rst_n = 1'b0;
            #1;
            chk_zero("async_rst");
            chk("rst_no_fd", 32'(fd_cnt0 - f0), 0);
        end else begin
            repeat (9) tick();                              // cycle 44
            chk("pad0_last_col", 32'(b0.col_idx), 9);
            tick();                                         // cycle 45
            chk("gap1_pad", 32'(b0.pad_row), 0);
            chk("gap1_row", 32'(b0.row_idx), 3);
            chk("gap1_vs", 32'(b0.dout_vsync), 1);
            if (mode == 1) begin
                repeat (12) tick(); vs = 1'b1;              // cycle 57
                tick();                                     // cycle 58
                chk("pad_vs_err", 32'(b0.err), 1);
                chk("pad_vs_pad", 32'(b0.pad_row), 1);
                repeat (26) tick();                         // cycle 84
            end else begin
                repeat (39) tick();                         // cycle 84
            end
            chk("pad2_pad", 32'(b0.pad_row), 1);
            chk("pad2_row", 32'(b0.row_idx), 4);
            chk("pad2_vs", 32'(b0.dout_vsync), 1);
            tick();                                         // cycle 85
            chk("flush_vs", 32'(b0.dout_vsync), 0);
            chk("flush_fd", 32'(b0.frame_done), 1);
            chk("flush_row", 32'(b0.row_idx), 4);
            tick();                                         // cycle 86
            chk("idle_fd", 32'(b0.frame_done), 0);
            chk("idle_row", 32'(b0.row_idx), 0);
            chk("pad_lines_k7", 32'(pad_cnt0 - p0), 3);
            chk("fd_count", 32'(fd_cnt0 - f0), 1);
            chk("err_count", 32'(err_cnt0 - e0), (mode == 1) ? 2 : 0);
            if (mode == 0) begin
                chk("pad_lines_k3", 32'(pad_cnt3 - p3), 1);
                chk("pad_lines_k5", 32'(pad_cnt5 - p5), 2);
            end
            if (mode == 1) begin
                repeat (5) tick();
                chk("no_restart", 32'(b0.dout_vsync), 0);
                vs = 1'b0;
                tick();
            end
        end
    endtask

    initial begin
        int f0, p0;
        repeat (3) tick();
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        frame_nom(0);
        repeat (3) tick();

        // early vsync drop after one line
        f0 = fd_cnt0; p0 = pad_cnt0;
        vs = 1'b1; tick();
        hs = 1'b1; repeat (10) tick(); hs = 1'b0;
        tick();
        chk("abort_row", 32'(b0.row_idx), 1);
        tick(); vs = 1'b0;
        chk("abort_vs_before", 32'(b0.dout_vsync), 1);
        tick();
        chk("abort_vs", 32'(b0.dout_vsync), 0);
        chk("abort_err", 32'(b0.err), 1);
        chk("abort_hs", 32'(b0.dout_hsync), 0);
        tick();
        chk("abort_err_pulse", 32'(b0.err), 0);
        repeat (20) tick();
        chk("abort_no_pad", 32'(pad_cnt0 - p0), 0);
        chk("abort_no_fd", 32'(fd_cnt0 - f0), 0);

        frame_nom(1);
        repeat (3) tick();

        frame_nom(2);
        vs = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("no_start_after_rst", 32'(b0.dout_vsync), 0);
        vs = 1'b0;
        repeat (2) tick();
        frame_nom(0);
        repeat (3) tick();

        // 9-pixel first line
        vs = 1'b1; tick();
        hs = 1'b1; repeat (9) tick(); hs = 1'b0;
        tick();
        chk("len_err_early", 32'(b0.err), 0);
        tick();
        chk("len_err", 32'(b0.err), LEN_EXP);
        chk("len_row", 32'(b0.row_idx), 1);
        tick(); vs = 1'b0;
        tick();
        chk("len_abort_err", 32'(b0.err), 1);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
